// File: rtl/sddt_rdata_pkg.sv
// rtl/sddt_rdata_pkg.sv - shared types and constants for the read-data AXI-Stream transmitter
// Contents: default DATA_W/KEEP_W, output FSM state enum, FIFO entry layout {last, data}.
package sddt_rdata_pkg;

   localparam int DATA_W = 512;
   localparam int KEEP_W = DATA_W / 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   // Entry layout at the default width; the FIFO stores the same packing flat
   // so that DATA_W overrides on the top level still work.
   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } rdata_entry_t;

endpackage

// File: rtl/rdata_fifo.sv
// rtl/rdata_fifo.sv - synchronous FIFO holding {last, data} read-beat entries
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     write strobe and entry; caller never pushes when full without a pop
//   pop, rdata      read strobe and head entry (rdata valid whenever !empty)
//   full, empty     occupancy flags
//   count           current occupancy, 0..DEPTH
module rdata_fifo
   import sddt_rdata_pkg::*;
#(
   parameter int W     = DATA_W + 1,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted in.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/rdata_axis_tx.sv
// rtl/rdata_axis_tx.sv - frames unstallable DDR read beats into an AXI-Stream master (M_AXIS_RDATA)
// Optional feature macro: RDATA_STATS_EN (beat/packet statistics counters).
// Ports:
//   c0_ddr4_clk, c0_ddr4_rst     clock, synchronous active-high reset
//   rd_valid, rd_data, rd_flush  read beat input (no backpressure); rd_flush closes the packet
//   M_AXIS_RDATA_*               stream master: tdata, tkeep (all ones), tlast, tvalid, tready
//   fifo_count                   FIFO occupancy, output register excluded
//   overflow, drop_count         sticky drop flag, saturating drop counter
//   stat_beats, stat_pkts        handshake counters (zero unless RDATA_STATS_EN)
module rdata_axis_tx
   import sddt_rdata_pkg::state_e, sddt_rdata_pkg::IDLE, sddt_rdata_pkg::HOLD;
#(
   parameter int DATA_W    = sddt_rdata_pkg::DATA_W,
   parameter int DEPTH     = 16,
   parameter int PKT_BEATS = 8
) (
   input  logic                     c0_ddr4_clk,
   input  logic                     c0_ddr4_rst,
   input  logic                     rd_valid,
   input  logic [DATA_W-1:0]        rd_data,
   input  logic                     rd_flush,
   output logic [DATA_W-1:0]        M_AXIS_RDATA_tdata,
   output logic [DATA_W/8-1:0]      M_AXIS_RDATA_tkeep,
   output logic                     M_AXIS_RDATA_tlast,
   output logic                     M_AXIS_RDATA_tvalid,
   input  logic                     M_AXIS_RDATA_tready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [15:0]              drop_count,
   output logic [31:0]              stat_beats,
   output logic [31:0]              stat_pkts
);

   localparam int CW = $clog2(PKT_BEATS) + 1;

   state_e            state_q, state_d;
   logic [DATA_W:0]   out_q, out_d;     // bit DATA_W is the last flag
   logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_q, drop_d;

   logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [DATA_W:0]   fifo_rdata;
   logic              last_in;

   rdata_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (c0_ddr4_clk),
      .rst   (c0_ddr4_rst),
      .push  (fifo_push),
      .wdata ({last_in, rd_data}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Refill the output register when it is free (IDLE) or being consumed now.
   assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || M_AXIS_RDATA_tready);
   // A full FIFO still takes a beat when the head leaves in the same cycle.
   assign fifo_push = rd_valid && (!fifo_full || fifo_pop);
   assign last_in   = (pkt_cnt_q == CW'(PKT_BEATS - 1)) || rd_flush;

   always_comb begin
      state_d    = state_q;
      out_d      = out_q;
      pkt_cnt_d  = pkt_cnt_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;

      if (fifo_pop) out_d = fifo_rdata;

      case (state_q)
         IDLE:    if (!fifo_empty) state_d = HOLD;
         HOLD:    if (M_AXIS_RDATA_tready && fifo_empty) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (fifo_push) begin
         pkt_cnt_d = last_in ? '0 : pkt_cnt_q + 1'b1;
      end else if (rd_valid) begin
         overflow_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge c0_ddr4_clk) begin
      if (c0_ddr4_rst) begin
         state_q    <= IDLE;
         out_q      <= '0;
         pkt_cnt_q  <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         pkt_cnt_q  <= pkt_cnt_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   assign M_AXIS_RDATA_tvalid = (state_q == HOLD);
   assign M_AXIS_RDATA_tdata  = out_q[DATA_W-1:0];
   assign M_AXIS_RDATA_tlast  = out_q[DATA_W] && (state_q == HOLD);
   assign M_AXIS_RDATA_tkeep  = '1;
   assign overflow            = overflow_q;
   assign drop_count          = drop_q;

`ifdef RDATA_STATS_EN
   logic [31:0] beats_q, beats_d;
   logic [31:0] pkts_q, pkts_d;
   logic        hs;

   assign hs = M_AXIS_RDATA_tvalid && M_AXIS_RDATA_tready;

   always_comb begin
      beats_d = beats_q;
      pkts_d  = pkts_q;
      if (hs)                      beats_d = beats_q + 32'd1;
      if (hs && M_AXIS_RDATA_tlast) pkts_d  = pkts_q + 32'd1;
   end

   always_ff @(posedge c0_ddr4_clk) begin
      if (c0_ddr4_rst) begin
         beats_q <= '0;
         pkts_q  <= '0;
      end else begin
         beats_q <= beats_d;
         pkts_q  <= pkts_d;
      end
   end

   assign stat_beats = beats_q;
   assign stat_pkts  = pkts_q;
`else
   assign stat_beats = '0;
   assign stat_pkts  = '0;
`endif

endmodule

// File: tb/tb_rdata_axis_tx.sv
// tb/tb_rdata_axis_tx.sv - self-checking bench for rdata_axis_tx (scoreboard + vector table)
module tb_rdata_axis_tx;

   localparam int DATA_W    = 512;
   localparam int KEEP_W    = DATA_W / 8;
   localparam int DEPTH     = 16;
   localparam int PKT_BEATS = 8;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   logic                c0_ddr4_clk = 1'b0;
   logic                c0_ddr4_rst;
   logic                rd_valid;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_flush;
   logic [DATA_W-1:0]   tdata;
   logic [KEEP_W-1:0]   tkeep;
   logic                tlast;
   logic                tvalid;
   logic                tready;
   logic [CNT_W-1:0]    fifo_count;
   logic                overflow;
   logic [15:0]         drop_count;
   logic [31:0]         stat_beats;
   logic [31:0]         stat_pkts;

   rdata_axis_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PKT_BEATS(PKT_BEATS)) dut (
      .c0_ddr4_clk         (c0_ddr4_clk),
      .c0_ddr4_rst         (c0_ddr4_rst),
      .rd_valid            (rd_valid),
      .rd_data             (rd_data),
      .rd_flush            (rd_flush),
      .M_AXIS_RDATA_tdata  (tdata),
      .M_AXIS_RDATA_tkeep  (tkeep),
      .M_AXIS_RDATA_tlast  (tlast),
      .M_AXIS_RDATA_tvalid (tvalid),
      .M_AXIS_RDATA_tready (tready),
      .fifo_count          (fifo_count),
      .overflow            (overflow),
      .drop_count          (drop_count),
      .stat_beats          (stat_beats),
      .stat_pkts           (stat_pkts)
   );

   always #5 c0_ddr4_clk = ~c0_ddr4_clk;

   typedef struct {
      int nbeats;
      int flush_at;     // 1-based beat index carrying rd_flush, 0 = none
      int rmode;        // 0 = tready high, 1 = toggle, 2 = tready low
      int exp_beats;
      int exp_lasts;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rmode    = 0;

   logic [DATA_W:0] sb[$];
   int              m_cnt;
   int              got_beats, got_lasts;
   bit              first_seen, first_marked;
   int              first_cyc, start_cyc;
   bit              prev_stall;
   logic [DATA_W:0] prev_beat;

   always @(posedge c0_ddr4_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      tready = 1'b0;
      forever begin
         @(posedge c0_ddr4_clk);
         #1;
         case (rmode)
            0:       tready = 1'b1;
            1:       tready = !tready;
            default: tready = 1'b0;
         endcase
      end
   end

   // Output monitor: scoreboard compare on each handshake, hold check on each stall.
   initial begin
      logic [DATA_W:0] exp;
      prev_stall = 1'b0;
      forever begin
         @(negedge c0_ddr4_clk);
         if (c0_ddr4_rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) chk("stall_hold", {tvalid, tlast, tdata}, {1'b1, prev_beat});
            if (tvalid && !first_seen) begin
               first_seen = 1'b1;
               first_cyc  = cyc;
            end
            if (tvalid && tready) begin
               got_beats++;
               if (tlast) got_lasts++;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got %0h with empty scoreboard", {tlast, tdata});
               end else begin
                  exp = sb.pop_front();
                  chk("beat", {tlast, tdata}, exp);
               end
            end
            prev_stall = tvalid && !tready;
            prev_beat  = {tlast, tdata};
         end
      end
   end

   task automatic do_reset(input int ncyc);
      c0_ddr4_rst = 1'b1;
      rd_valid    = 1'b0;
      rd_flush    = 1'b0;
      repeat (ncyc) @(posedge c0_ddr4_clk);
      #1;
      c0_ddr4_rst  = 1'b0;
      sb.delete();
      m_cnt        = 0;
      got_beats    = 0;
      got_lasts    = 0;
      first_seen   = 1'b0;
      first_marked = 1'b0;
   endtask

   task automatic send(input int idx, input bit flush, input bit keep);
      logic [DATA_W-1:0] d;
      bit                last;
      d        = {16{32'(idx)}};
      rd_valid = 1'b1;
      rd_data  = d;
      rd_flush = flush;
      last     = (m_cnt == PKT_BEATS - 1) || flush;
      if (keep) begin
         sb.push_back({last, d});
         m_cnt = last ? 0 : m_cnt + 1;
      end
      if (!first_marked) begin
         first_marked = 1'b1;
         start_cyc    = cyc;
      end
      @(posedge c0_ddr4_clk);
      #1;
      rd_valid = 1'b0;
      rd_flush = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || tvalid) && t < 400) begin
         @(posedge c0_ddr4_clk);
         #1;
         t++;
      end
      chk("drain_done", (DATA_W+1)'(t < 400), (DATA_W+1)'(1));
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{nbeats: 8,  flush_at: 0, rmode: 0, exp_beats: 8,  exp_lasts: 1};
      vecs[1] = '{nbeats: 11, flush_at: 3, rmode: 0, exp_beats: 11, exp_lasts: 2};
      vecs[2] = '{nbeats: 32, flush_at: 0, rmode: 1, exp_beats: 32, exp_lasts: 4};
      vecs[3] = '{nbeats: 24, flush_at: 0, rmode: 0, exp_beats: 24, exp_lasts: 3};

      rd_data = '0;
      do_reset(3);
      @(negedge c0_ddr4_clk);
      chk("rst_tvalid",     (DATA_W+1)'(tvalid),     '0);
      chk("rst_tlast",      (DATA_W+1)'(tlast),      '0);
      chk("rst_tdata",      (DATA_W+1)'(tdata),      '0);
      chk("rst_tkeep",      (DATA_W+1)'(tkeep),      (DATA_W+1)'({KEEP_W{1'b1}}));
      chk("rst_fifo_count", (DATA_W+1)'(fifo_count), '0);
      chk("rst_overflow",   (DATA_W+1)'(overflow),   '0);
      chk("rst_drop_count", (DATA_W+1)'(drop_count), '0);
      chk("rst_stat_beats", (DATA_W+1)'(stat_beats), '0);
      chk("rst_stat_pkts",  (DATA_W+1)'(stat_pkts),  '0);

      for (int v = 0; v < 4; v++) begin
         int exp_sb, exp_sp;
         do_reset(1);
         rmode = vecs[v].rmode;
         @(posedge c0_ddr4_clk);
         #1;
         for (int i = 0; i < vecs[v].nbeats; i++)
            send(v * 100 + i, (i + 1) == vecs[v].flush_at, 1'b1);
         drain();
`ifdef RDATA_STATS_EN
         exp_sb = vecs[v].exp_beats;
         exp_sp = vecs[v].exp_lasts;
`else
         exp_sb = 0;
         exp_sp = 0;
`endif
         chk("vec_beats",      (DATA_W+1)'(got_beats),  (DATA_W+1)'(vecs[v].exp_beats));
         chk("vec_lasts",      (DATA_W+1)'(got_lasts),  (DATA_W+1)'(vecs[v].exp_lasts));
         chk("vec_latency",    (DATA_W+1)'(first_cyc),  (DATA_W+1)'(start_cyc + 2));
         chk("vec_overflow",   (DATA_W+1)'(overflow),   '0);
         chk("vec_stat_beats", (DATA_W+1)'(stat_beats), (DATA_W+1)'(exp_sb));
         chk("vec_stat_pkts",  (DATA_W+1)'(stat_pkts),  (DATA_W+1)'(exp_sp));
      end

      // Overflow: 18 beats into a stalled stream, 17 fit (FIFO + output register).
      do_reset(1);
      rmode = 2;
      @(posedge c0_ddr4_clk);
      #1;
      for (int i = 0; i < 18; i++) send(1000 + i, 1'b0, i < 17);
      @(negedge c0_ddr4_clk);
      chk("ovf_overflow",   (DATA_W+1)'(overflow),   (DATA_W+1)'(1));
      chk("ovf_drop_count", (DATA_W+1)'(drop_count), (DATA_W+1)'(1));
      chk("ovf_fifo_count", (DATA_W+1)'(fifo_count), (DATA_W+1)'(16));
      chk("ovf_tvalid",     (DATA_W+1)'(tvalid),     (DATA_W+1)'(1));
      rmode = 0;
      drain();
      chk("ovf_beats", (DATA_W+1)'(got_beats), (DATA_W+1)'(17));
      chk("ovf_lasts", (DATA_W+1)'(got_lasts), (DATA_W+1)'(2));
      chk("ovf_sticky", (DATA_W+1)'(overflow), (DATA_W+1)'(1));

      // Reset mid-packet discards buffered beats and the partial packet.
      do_reset(1);
      rmode = 2;
      @(posedge c0_ddr4_clk);
      #1;
      for (int i = 0; i < 5; i++) send(2000 + i, 1'b0, 1'b1);
      @(negedge c0_ddr4_clk);
      chk("mid_tvalid_pre", (DATA_W+1)'(tvalid), (DATA_W+1)'(1));
      @(posedge c0_ddr4_clk);
      #1;
      do_reset(1);
      @(negedge c0_ddr4_clk);
      chk("mid_tvalid",     (DATA_W+1)'(tvalid),     '0);
      chk("mid_fifo_count", (DATA_W+1)'(fifo_count), '0);
      rmode = 0;
      @(posedge c0_ddr4_clk);
      #1;
      for (int i = 0; i < 8; i++) send(3000 + i, 1'b0, 1'b1);
      drain();
      chk("mid_beats", (DATA_W+1)'(got_beats), (DATA_W+1)'(8));
      chk("mid_lasts", (DATA_W+1)'(got_lasts), (DATA_W+1)'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
